// File: rtl/mm_result_drain.sv
// rtl/mm_result_drain.sv - captures c0/c1/c2 result rows and drains them as 64-bit beats
// Optional trailing XOR checksum beat: define MM_DRAIN_CHECKSUM_EN.
module mm_result_drain #(
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ARRAY_SIZE        = 8,
  parameter int ROWS              = 8,
  localparam int HW               = ARRAY_SIZE / 2 * OUTPUT_DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en_c0,
  input  logic          wr_en_c1,
  input  logic          wr_en_c2,
  input  logic [5:0]    waddr_c0,
  input  logic [5:0]    waddr_c1,
  input  logic [5:0]    waddr_c2,
  input  logic [HW-1:0] wdata_c00,
  input  logic [HW-1:0] wdata_c10,
  input  logic [HW-1:0] wdata_c20,
  input  logic [HW-1:0] wdata_c01,
  input  logic [HW-1:0] wdata_c11,
  input  logic [HW-1:0] wdata_c21,
  input  logic          drain_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [HW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          overrun,
  output logic          missing
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HI,
    S_LO
`ifdef MM_DRAIN_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t          r_state;
  logic [2*HW-1:0] r_mem [0:2][0:63];
  logic [63:0]     r_written [0:2];
  logic [1:0]      r_bank;
  logic [5:0]      r_row;
  logic [HW-1:0]   r_lo;
  logic            r_out_valid;
  logic            r_out_last;
  logic [HW-1:0]   r_out_data;
  logic            r_overrun;
  logic            r_missing;
`ifdef MM_DRAIN_CHECKSUM_EN
  logic [HW-1:0]   r_csum;
`endif

  logic w_fire;
  logic w_last_row;
  logic w_any_wr;
  logic w_idle;

  assign w_fire     = r_out_valid && out_ready;
  assign w_last_row = (r_bank == 2'd2) && (r_row == LAST_ROW);
  assign w_any_wr   = wr_en_c0 || wr_en_c1 || wr_en_c2;
  assign w_idle     = (r_state == S_IDLE);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = !w_idle;
  assign overrun   = r_overrun;
  assign missing   = r_missing;

  // Row storage carries no reset; the written bitmap decides what is valid.
  always_ff @(posedge clock) begin
    if (w_idle) begin
      if (wr_en_c0) r_mem[0][waddr_c0] <= {wdata_c00, wdata_c01};
      if (wr_en_c1) r_mem[1][waddr_c1] <= {wdata_c10, wdata_c11};
      if (wr_en_c2) r_mem[2][waddr_c2] <= {wdata_c20, wdata_c21};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_written[0] <= '0;
      r_written[1] <= '0;
      r_written[2] <= '0;
      r_bank       <= '0;
      r_row        <= '0;
      r_lo         <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_overrun    <= 1'b0;
      r_missing    <= 1'b0;
`ifdef MM_DRAIN_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      if (w_idle) begin
        if (wr_en_c0) r_written[0][waddr_c0] <= 1'b1;
        if (wr_en_c1) r_written[1][waddr_c1] <= 1'b1;
        if (wr_en_c2) r_written[2][waddr_c2] <= 1'b1;
      end else if (w_any_wr) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (drain_start) begin
            r_state   <= S_FETCH;
            r_bank    <= 2'd0;
            r_row     <= 6'd0;
            r_overrun <= 1'b0;
            r_missing <= 1'b0;
`ifdef MM_DRAIN_CHECKSUM_EN
            r_csum    <= '0;
`endif
          end
        end
        S_FETCH: begin
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          if (r_written[r_bank][r_row]) begin
            r_out_data <= r_mem[r_bank][r_row][2*HW-1:HW];
            r_lo       <= r_mem[r_bank][r_row][HW-1:0];
          end else begin
            r_out_data <= '0;
            r_lo       <= '0;
            r_missing  <= 1'b1;
          end
          r_state <= S_HI;
        end
        S_HI: begin
          if (w_fire) begin
            r_out_data <= r_lo;
`ifdef MM_DRAIN_CHECKSUM_EN
            r_csum     <= r_csum ^ r_out_data;
            r_out_last <= 1'b0;
`else
            r_out_last <= w_last_row;
`endif
            r_state    <= S_LO;
          end
        end
        S_LO: begin
          if (w_fire) begin
            if (w_last_row) begin
`ifdef MM_DRAIN_CHECKSUM_EN
              // r_csum already holds every earlier beat; fold in this one.
              r_out_data <= r_csum ^ r_out_data;
              r_out_last <= 1'b1;
              r_state    <= S_CSUM;
`else
              r_out_valid  <= 1'b0;
              r_out_last   <= 1'b0;
              r_written[0] <= '0;
              r_written[1] <= '0;
              r_written[2] <= '0;
              r_state      <= S_IDLE;
`endif
            end else begin
`ifdef MM_DRAIN_CHECKSUM_EN
              r_csum <= r_csum ^ r_out_data;
`endif
              r_out_valid <= 1'b0;
              if (r_row == LAST_ROW) begin
                r_row  <= 6'd0;
                r_bank <= r_bank + 2'd1;
              end else begin
                r_row <= r_row + 6'd1;
              end
              r_state <= S_FETCH;
            end
          end
        end
`ifdef MM_DRAIN_CHECKSUM_EN
        S_CSUM: begin
          if (w_fire) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_written[0] <= '0;
            r_written[1] <= '0;
            r_written[2] <= '0;
            r_state      <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_result_drain.sv
// tb/tb_mm_result_drain.sv - scoreboard bench for mm_result_drain
// Honours MM_DRAIN_CHECKSUM_EN when the build defines it.
module tb_mm_result_drain;
  localparam int HW   = 64;
  localparam int ROWS = 8;
`ifdef MM_DRAIN_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en_c0, wr_en_c1, wr_en_c2;
  logic [5:0]    waddr_c0, waddr_c1, waddr_c2;
  logic [HW-1:0] wdata_c00, wdata_c10, wdata_c20;
  logic [HW-1:0] wdata_c01, wdata_c11, wdata_c21;
  logic          drain_start;
  logic          out_valid;
  logic          out_ready;
  logic [HW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic          missing;

  mm_result_drain #(.OUTPUT_DATA_WIDTH(16), .ARRAY_SIZE(8), .ROWS(ROWS)) dut (
    .clock(clock), .reset(reset),
    .wr_en_c0(wr_en_c0), .wr_en_c1(wr_en_c1), .wr_en_c2(wr_en_c2),
    .waddr_c0(waddr_c0), .waddr_c1(waddr_c1), .waddr_c2(waddr_c2),
    .wdata_c00(wdata_c00), .wdata_c10(wdata_c10), .wdata_c20(wdata_c20),
    .wdata_c01(wdata_c01), .wdata_c11(wdata_c11), .wdata_c21(wdata_c21),
    .drain_start(drain_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .overrun(overrun), .missing(missing)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        e;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           beat_cnt = 0;
  logic         ready_toggle = 1'b0;
  logic [127:0] m_mem [0:2][0:63];
  logic         m_wr  [0:2][0:63];
  logic         stall_prev = 1'b0;
  logic [64:0]  stall_val;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold during stalls.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", 65'(out_valid), 65'd1);
        check("stall_data_held", {out_last, out_data}, stall_val);
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 65'd1, 65'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d_data", beat_cnt), 65'(out_data), 65'(e.data));
          check($sformatf("beat%0d_last", beat_cnt), 65'(out_last), 65'(e.last));
        end
        stall_prev = 1'b0;
      end else if (out_valid) begin
        stall_prev = 1'b1;
        stall_val  = {out_last, out_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = ready_toggle ? ~out_ready : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] row_val(input int b, input int r, input int pat);
    logic [63:0] hi, lo;
    if (pat == 1) begin
      hi = 64'h0123456789ABCDEF;
      lo = 64'h0123456789ABCDEF;
    end else begin
      hi = {16'hC0DE, 8'(b), 8'(r), 32'h0000_000A};
      lo = {16'hBEEF, 8'(b), 8'(r), 32'h0000_000B};
    end
    return {hi, lo};
  endfunction

  task automatic drive_bank(input int b, input logic en, input logic [5:0] a, input logic [127:0] d);
    case (b)
      0: begin wr_en_c0 = en; waddr_c0 = a; wdata_c00 = d[127:64]; wdata_c01 = d[63:0]; end
      1: begin wr_en_c1 = en; waddr_c1 = a; wdata_c10 = d[127:64]; wdata_c11 = d[63:0]; end
      default: begin wr_en_c2 = en; waddr_c2 = a; wdata_c20 = d[127:64]; wdata_c21 = d[63:0]; end
    endcase
  endtask

  task automatic write_model(input int b, input int r, input int pat);
    drive_bank(b, 1'b1, 6'(r), row_val(b, r, pat));
    m_mem[b][r] = row_val(b, r, pat);
    m_wr[b][r]  = 1'b1;
  endtask

  task automatic idle_writes();
    for (int b = 0; b < 3; b++) drive_bank(b, 1'b0, 6'd0, 128'd0);
  endtask

  task automatic clear_model();
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 64; r++) m_wr[b][r] = 1'b0;
  endtask

  task automatic fill(input int skip_b, input int skip_r, input int pat, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int b = 0; b < 3; b++) begin
        if (b == skip_b && r == skip_r) drive_bank(b, 1'b0, 6'd0, 128'd0);
        else write_model(b, r, pat);
      end
      tick();
    end
    idle_writes();
  endtask

  task automatic push_drain();
    logic [127:0] d;
    logic [63:0]  cs;
    cs = 64'd0;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < ROWS; r++) begin
        d = m_wr[b][r] ? m_mem[b][r] : 128'd0;
        exp_q.push_back('{last: 1'b0, data: d[127:64]});
        exp_q.push_back('{last: (EXTRA == 0 && b == 2 && r == ROWS - 1), data: d[63:0]});
        cs = cs ^ d[127:64] ^ d[63:0];
      end
    end
    if (EXTRA == 1) exp_q.push_back('{last: 1'b1, data: cs});
    clear_model();
  endtask

  task automatic drain(input bit same_cycle_wr, input bit wr_during, input bit start_during,
                       input logic exp_missing, input logic exp_overrun, output int busy_cnt);
    int guard;
    if (same_cycle_wr)
      for (int b = 0; b < 3; b++) write_model(b, ROWS - 1, 0);
    drain_start = 1'b1;
    push_drain();
    tick();
    drain_start = 1'b0;
    idle_writes();
    check("fetch_no_valid", 65'(out_valid), 65'd0);
    check("busy_after_start", 65'(busy), 65'd1);
    check("overrun_cleared_on_start", 65'(overrun), 65'd0);
    check("missing_cleared_on_start", 65'(missing), 65'd0);
    tick();
    check("first_valid_at_t2", 65'(out_valid), 65'd1);
    busy_cnt = busy ? 2 : 1;
    guard = 0;
    while (busy && guard < 2000) begin
      if (wr_during && guard == 10) drive_bank(2, 1'b1, 6'd0, {64'hDEAD_0000_0000_DEAD, 64'hFEED_0000_0000_FEED});
      else if (wr_during && guard == 11) idle_writes();
      drain_start = (start_during && guard == 20);
      tick();
      guard++;
      if (busy) busy_cnt++;
    end
    drain_start = 1'b0;
    idle_writes();
    if (guard >= 2000) check("drain_timeout", 65'd1, 65'd0);
    check("queue_drained", 65'(exp_q.size()), 65'd0);
    check("valid_low_after", 65'(out_valid), 65'd0);
    check("last_low_after", 65'(out_last), 65'd0);
    check("missing_after", 65'(missing), 65'(exp_missing));
    check("overrun_after", 65'(overrun), 65'(exp_overrun));
  endtask

  initial begin
    int cyc;
    int base;
    int guard;
    reset = 1'b1;
    drain_start = 1'b0;
    idle_writes();
    clear_model();
    repeat (3) tick();
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_out_data", 65'(out_data), 65'd0);
    check("rst_out_last", 65'(out_last), 65'd0);
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_overrun", 65'(overrun), 65'd0);
    check("rst_missing", 65'(missing), 65'd0);
    reset = 1'b0;
    tick();

    // Full fill, ready held high.
    fill(-1, -1, 0, ROWS);
    base = beat_cnt;
    drain(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
    check("drain_cycles", 65'(cyc), 65'(9 * ROWS + EXTRA));
    check("beat_count", 65'(beat_cnt - base), 65'(6 * ROWS + EXTRA));

    // Toggling ready, last rows written alongside drain_start, ignored restart mid-drain.
    ready_toggle = 1'b1;
    fill(-1, -1, 0, ROWS - 1);
    base = beat_cnt;
    drain(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cyc);
    check("beat_count_toggle", 65'(beat_cnt - base), 65'(6 * ROWS + EXTRA));
    ready_toggle = 1'b0;
    tick();
    tick();

    // Bank 1 row 3 never written -> beats 23/24 zero.
    fill(1, 3, 0, ROWS);
    drain(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cyc);

    // Write during drain is dropped and flagged; next drain sees empty bitmap.
    fill(-1, -1, 0, ROWS);
    drain(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cyc);
    drain(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cyc);

    // Reset after beat 10, then a normal fill/drain.
    fill(-1, -1, 0, ROWS);
    base = beat_cnt;
    drain_start = 1'b1;
    push_drain();
    tick();
    drain_start = 1'b0;
    guard = 0;
    while (beat_cnt < base + 10 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("beat10_timeout", 65'd1, 65'd0);
    reset = 1'b1;
    tick();
    check("midreset_valid", 65'(out_valid), 65'd0);
    check("midreset_busy", 65'(busy), 65'd0);
    reset = 1'b0;
    exp_q.delete();
    clear_model();
    tick();
    fill(-1, -1, 0, ROWS);
    drain(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);

    // Uniform pattern: checksum beat (when enabled) is zero.
    fill(-1, -1, 1, ROWS);
    base = beat_cnt;
    drain(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
    check("beat_count_uniform", 65'(beat_cnt - base), 65'(6 * ROWS + EXTRA));
    check("drain_cycles_uniform", 65'(cyc), 65'(9 * ROWS + EXTRA));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
